// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes the instruction format, builds the XLEN-wide
// immediate and pc+imm target, and queues results in a 2-entry elastic buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV64_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned DEPTH = 2;
  localparam bit RV64_EN = RV64_OPS && (XLEN == 64);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w, zimm;
  logic [XLEN-1:0] dec_imm, dec_target;
  logic [2:0]      dec_fmt;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Per-format immediate candidates; the decode below only selects among them
  assign imm_i   = XLEN'($signed(in_instr[31:20]));
  assign imm_s   = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b   = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign shamt   = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign shamt_w = XLEN'(in_instr[24:20]);
  assign zimm    = XLEN'(in_instr[19:15]);

  // Format decode; anything not matched stays illegal with a zero immediate
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD, OPC_JALR: begin dec_fmt = FMT_I; dec_imm = imm_i; end
        OPC_OP_IMM:         begin dec_fmt = FMT_I; dec_imm = is_shift ? shamt : imm_i; end
        OPC_OP_IMM32: begin
          if (RV64_EN) begin
            dec_fmt = FMT_I;
            dec_imm = is_shift ? shamt_w : imm_i;
          end
        end
        OPC_STORE:          begin dec_fmt = FMT_S; dec_imm = imm_s; end
        OPC_BRANCH:         begin dec_fmt = FMT_B; dec_imm = imm_b; end
        OPC_LUI, OPC_AUIPC: begin dec_fmt = FMT_U; dec_imm = imm_u; end
        OPC_JAL:            begin dec_fmt = FMT_J; dec_imm = imm_j; end
        OPC_SYSTEM: begin
          dec_fmt = funct3[2] ? FMT_Z : FMT_I;
          dec_imm = funct3[2] ? zimm : '0;
        end
        OPC_OP:   dec_fmt = FMT_R;
        OPC_OP32: dec_fmt = RV64_EN ? FMT_R : FMT_ILL;
        default:  dec_fmt = FMT_ILL;
      endcase
    end
  end

  assign dec_target = in_pc + dec_imm;

  logic [XLEN-1:0] mem_imm [DEPTH];
  logic [XLEN-1:0] mem_tgt [DEPTH];
  logic [2:0]      mem_fmt [DEPTH];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic            push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Elastic buffer; reset also clears storage so the head reads as zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_tgt[i] <= '0;
        mem_fmt[i] <= FMT_R;
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_tgt[wr_ptr] <= dec_target;
        mem_fmt[wr_ptr] <= dec_fmt;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_imm     = mem_imm[rd_ptr];
  assign out_target  = mem_tgt[rd_ptr];
  assign out_fmt     = mem_fmt[rd_ptr];
  assign out_illegal = (mem_fmt[rd_ptr] == FMT_ILL);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance, expected
// entries queued at acceptance and compared against the head whenever out_valid is high.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush;

  logic        v32, r32, rdy32, ov32, oill32;
  logic [31:0] i32, pc32, oimm32, otgt32;
  logic [2:0]  ofmt32;

  logic        v64, r64, rdy64, ov64, oill64;
  logic [31:0] i64;
  logic [63:0] pc64, oimm64, otgt64;
  logic [2:0]  ofmt64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v32), .in_ready(rdy32), .in_instr(i32), .in_pc(pc32),
    .out_valid(ov32), .out_ready(r32), .out_imm(oimm32), .out_target(otgt32),
    .out_fmt(ofmt32), .out_illegal(oill32)
  );

  imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v64), .in_ready(rdy64), .in_instr(i64), .in_pc(pc64),
    .out_valid(ov64), .out_ready(r64), .out_imm(oimm64), .out_target(otgt64),
    .out_fmt(ofmt64), .out_illegal(oill64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference decode for the XLEN=32 instance
  function automatic void ref_dec32(input logic [31:0] ins, output logic [31:0] imm,
                                    output logic [2:0] fmt);
    logic [2:0] f3;
    f3  = ins[14:12];
    imm = 32'd0;
    fmt = 3'd7;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h03, 7'h67: begin fmt = 3'd1; imm = {{20{ins[31]}}, ins[31:20]}; end
        7'h13: begin
          fmt = 3'd1;
          imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
        end
        7'h23: begin fmt = 3'd2; imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
        7'h63: begin fmt = 3'd3; imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
        7'h37, 7'h17: begin fmt = 3'd4; imm = {ins[31:12], 12'd0}; end
        7'h6F: begin fmt = 3'd5; imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
        7'h73: begin fmt = f3[2] ? 3'd6 : 3'd1; imm = f3[2] ? {27'd0, ins[19:15]} : 32'd0; end
        7'h33: fmt = 3'd0;
        default: fmt = 3'd7;
      endcase
    end
  endfunction

  // Head of each buffer is compared every cycle it is valid; popped only on handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov32) begin
      if (q32.size() == 0) check_eq("unexpected_out32", 64'(oimm32), 64'hDEAD_0000_0000_0000);
      else begin
        e = q32[0];
        check_eq("imm32", 64'(oimm32), 64'(e.imm[31:0]));
        check_eq("tgt32", 64'(otgt32), 64'(e.tgt[31:0]));
        check_eq("fmt32", 64'(ofmt32), 64'(e.fmt));
        check_eq("ill32", 64'(oill32), 64'(e.fmt == 3'd7));
        if (r32) void'(q32.pop_front());
      end
    end
    if (!rst && ov64) begin
      if (q64.size() == 0) check_eq("unexpected_out64", oimm64, 64'hDEAD_0000_0000_0000);
      else begin
        e = q64[0];
        check_eq("imm64", oimm64, e.imm);
        check_eq("tgt64", otgt64, e.tgt);
        check_eq("fmt64", 64'(ofmt64), 64'(e.fmt));
        check_eq("ill64", 64'(oill64), 64'(e.fmt == 3'd7));
        if (r64) void'(q64.pop_front());
      end
    end
  end

  task automatic send(input bit s64, input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] eimm, input logic [2:0] efmt);
    exp_t e;
    bit   done;
    done  = 1'b0;
    e.imm = eimm;
    e.tgt = pc + eimm;
    e.fmt = efmt;
    if (s64) begin v64 = 1'b1; i64 = ins; pc64 = pc; end
    else begin v32 = 1'b1; i32 = ins; pc32 = pc[31:0]; end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (s64 ? rdy64 : rdy32) begin
        if (s64) q64.push_back(e);
        else q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (s64) v64 = 1'b0;
    else v32 = 1'b0;
    if (!done) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input bit s64);
    if (s64) r64 = 1'b1;
    else r32 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if ((s64 ? q64.size() : q32.size()) == 0) break;
      @(posedge clk);
      #1;
    end
    check_eq(s64 ? "drain64" : "drain32", 64'(s64 ? q64.size() : q32.size()), 64'd0);
  endtask

  task automatic check_reset();
    check_eq("rst_valid32", 64'(ov32),   64'd0);
    check_eq("rst_ready32", 64'(rdy32),  64'd1);
    check_eq("rst_imm32",   64'(oimm32), 64'd0);
    check_eq("rst_tgt32",   64'(otgt32), 64'd0);
    check_eq("rst_fmt32",   64'(ofmt32), 64'd0);
    check_eq("rst_ill32",   64'(oill32), 64'd0);
    check_eq("rst_valid64", 64'(ov64),   64'd0);
    check_eq("rst_ready64", 64'(rdy64),  64'd1);
    check_eq("rst_imm64",   oimm64,      64'd0);
    check_eq("rst_tgt64",   otgt64,      64'd0);
    check_eq("rst_fmt64",   64'(ofmt64), 64'd0);
    check_eq("rst_ill64",   64'(oill64), 64'd0);
  endtask

  initial begin
    logic [6:0]  ops [13];
    logic [31:0] rins, rimm;
    logic [2:0]  rfmt;
    exp_t        e;
    ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F};

    rst = 1'b1; flush = 1'b0;
    v32 = 1'b1; i32 = 32'h0000_0013; pc32 = '0; r32 = 1'b1;
    v64 = 1'b1; i64 = 32'h0000_0013; pc64 = '0; r64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; v32 = 1'b0; v64 = 1'b0;
    @(negedge clk);
    check_reset();

    // addi x1,x2,-4 with single-cycle latency into an empty buffer
    @(posedge clk); #1;
    send(1'b0, 32'hFFC1_0093, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1);
    check_eq("lat_valid32", 64'(ov32), 64'd1);
    check_eq("lat_imm32", 64'(oimm32), 64'hFFFF_FFFC);
    drain(1'b0);

    send(1'b0, 32'hFE20_8EE3, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    send(1'b0, 32'h1000_00EF, 64'h100,  64'h100, 3'd5);
    send(1'b0, 32'h4051_5093, 64'h40,   64'h5,   3'd1);
    send(1'b0, 32'h340F_D073, 64'h2000, 64'h1F,  3'd6);
    send(1'b0, 32'hFFF0_809B, 64'h44,   64'h0,   3'd7);
    send(1'b0, 32'h0200_9093, 64'h48,   64'h0,   3'd1);
    send(1'b0, 32'h0000_0010, 64'h4C,   64'h0,   3'd7);
    drain(1'b0);

    send(1'b1, 32'h8000_00B7, 64'h10,   64'hFFFF_FFFF_8000_0000, 3'd4);
    send(1'b1, 32'h0000_0000, 64'h20,   64'h0,  3'd7);
    send(1'b1, 32'h0200_9093, 64'h24,   64'h20, 3'd1);
    send(1'b1, 32'hFFF0_809B, 64'h28,   64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    send(1'b1, 32'h4250_D09B, 64'h2C,   64'h5,  3'd1);
    send(1'b1, 32'h0020_80BB, 64'h30,   64'h0,  3'd0);
    send(1'b1, 32'hFE20_8EE3, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    drain(1'b1);

    // Backpressure: two accepted, third held while the head stays stable
    r32 = 1'b0;
    send(1'b0, 32'h0010_0093, 64'h100, 64'h1, 3'd1);
    send(1'b0, 32'h0020_0093, 64'h104, 64'h2, 3'd1);
    v32 = 1'b1; i32 = 32'h0030_0093; pc32 = 32'h108;
    @(negedge clk);
    check_eq("full_ready32", 64'(rdy32), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    r32 = 1'b1;
    send(1'b0, 32'h0030_0093, 64'h108, 64'h3, 3'd1);
    drain(1'b0);

    // Flush at count 2 with an instruction offered
    r32 = 1'b0;
    send(1'b0, 32'h0040_0093, 64'h200, 64'h4, 3'd1);
    send(1'b0, 32'h0050_0093, 64'h204, 64'h5, 3'd1);
    flush = 1'b1; v32 = 1'b1; i32 = 32'h0060_0093; pc32 = 32'h208;
    @(posedge clk); #1;
    flush = 1'b0; v32 = 1'b0;
    q32.delete(); q64.delete();
    @(negedge clk);
    check_eq("flush_valid32", 64'(ov32), 64'd0);
    check_eq("flush_ready32", 64'(rdy32), 64'd1);
    @(posedge clk); #1;
    r32 = 1'b1;
    send(1'b0, 32'h0070_0093, 64'h20C, 64'h7, 3'd1);
    drain(1'b0);

    // Random stream with random backpressure against the reference decode
    for (int k = 0; k < 40; ) begin
      rins = $urandom();
      rins[6:0] = ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) rins[1:0] = 2'($urandom_range(0, 2));
      v32 = 1'b1; i32 = rins; pc32 = $urandom();
      ref_dec32(rins, rimm, rfmt);
      e.imm = 64'(rimm); e.tgt = 64'(pc32 + rimm); e.fmt = rfmt;
      for (int w = 0; w < 50; w++) begin
        r32 = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (rdy32) begin
          q32.push_back(e);
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        if (w == 49) check_eq("rand_timeout", 64'd0, 64'd1);
      end
      k++;
    end
    v32 = 1'b0;
    drain(1'b0);

    // Reset mid-stream discards everything in both instances
    r32 = 1'b0; r64 = 1'b0;
    send(1'b0, 32'h0080_0093, 64'h300, 64'h8, 3'd1);
    send(1'b0, 32'h0090_0093, 64'h304, 64'h9, 3'd1);
    send(1'b1, 32'h00A0_0093, 64'h308, 64'hA, 3'd1);
    rst = 1'b1; v32 = 1'b1; v64 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; v32 = 1'b0; v64 = 1'b0;
    q32.delete(); q64.delete();
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    send(1'b1, 32'h00B0_0093, 64'h30C, 64'hB, 3'd1);
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
